instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 64'h0, the fetch address after reset; bits [1:0] are treated as 0.
REQ-002 The block SHALL have ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  synchronous, active-high reset.
- iStall  in  1  downstream hold; the presented instruction is not consumed.
- iBranch  in  1  redirect request from the branch decision for the presented instruction.
- iBranchOffset  in  64  signed word offset of the branch.
- iFlush  in  1  restart request; highest priority.
- iFlushPC  in  64  restart address; bits [1:0] are ignored.
- oIMemReq  out  1  instruction-memory read request.
- oIMemAddr  out  64  request byte address; bits [1:0] are always 0.
- iIMemReady  in  1  memory accepts the request this cycle.
- iIMemValid  in  1  read data valid.
- iIMemData  in  32  read data.
- oInstruction  out  32  instruction word to the control unit.
- oPC  out  64  address of oInstruction.
- oValid  out  1  oInstruction/oPC are valid.

Function
REQ-003 The block SHALL hold a 64-bit fetch PC (fpc) and a state machine with states FETCH, WAIT, HOLD and DROP.
REQ-004 In FETCH, oIMemReq SHALL be 1 and oIMemAddr SHALL equal fpc.
- iIMemReady=1 → WAIT next cycle.
- Otherwise stay in FETCH with the request and address held stable.
REQ-005 In every state other than FETCH, oIMemReq SHALL be 0.
REQ-006 In WAIT, on iIMemValid=1 the block SHALL load oInstruction<=iIMemData and oPC<=fpc, and go to HOLD; oValid rises the next cycle.
REQ-007 oValid SHALL be 1 exactly when state is HOLD.
REQ-008 The instruction is consumed in HOLD when iStall=0.
- iBranch=1 at consumption → fpc<=oPC+(iBranchOffset<<2) (modulo 2^64), go to FETCH.
- iBranch=0 → fpc<=oPC+4 (modulo 2^64), go to FETCH.
REQ-009 In HOLD with iStall=1, oInstruction, oPC and oValid SHALL hold unchanged, and iBranch SHALL be ignored.
REQ-010 iIMemValid SHALL be ignored in FETCH and HOLD.
- Response data is never accepted in the same cycle as the request is accepted.
REQ-011 iFlush=1 SHALL load fpc<={iFlushPC[63:2],2'b00} and override every other input in the same cycle.
- From FETCH or HOLD → FETCH.
- From WAIT without iIMemValid → DROP.
- From WAIT with iIMemValid=1 → FETCH, with the data discarded.
REQ-012 In DROP, the next iIMemValid=1 response SHALL be discarded and the state SHALL go to FETCH.
- A further iFlush in DROP updates fpc and stays in DROP.
REQ-013 oValid SHALL fall on the cycle after any flush; a flushed or dropped instruction SHALL never appear with oValid=1.
REQ-014 The minimum latency with zero-wait memory SHALL be 3 cycles per instruction: FETCH→WAIT→HOLD.

Reset
REQ-015 While iRST=1, the block SHALL drive oIMemReq=0 and oValid=0.
REQ-016 On a clock edge with iRST=1, the block SHALL set:
- state=FETCH
- fpc=RESET_PC
- oPC=RESET_PC
- oInstruction=32'h0
REQ-017 Reset SHALL override iFlush and iBranch, and a response pending at reset SHALL be discarded.
- Memory is required to be reset alongside this block.
REQ-018 After iRST falls, oIMemReq SHALL be 1 in the first cycle, with oIMemAddr=RESET_PC.

Verification
REQ-019 Sequential fetch: RESET_PC=0, ready=1, memory returns data one cycle after accept, iStall=0.
- Expected: oValid pulses with oPC = 0, 4, 8, each 3 cycles apart, and oInstruction matching memory.
REQ-020 Stall: iStall=1 for 5 cycles while oPC=4.
- Expected: oValid, oPC and oInstruction are held for 5 cycles, no oIMemReq, then the next fetch addr is 8.
REQ-021 Branch: oPC=16, iBranch=1, iBranchOffset=-2.
- Expected: next oIMemAddr=8.
- Also: oPC=64'hFFFF_FFFF_FFFF_FFFC with sequential flow → next address 0 (wrap-around).
REQ-022 Flush in WAIT: iFlush=1 with iFlushPC=0x103 while awaiting data.
- Expected: the late response is dropped with oValid held 0, then oIMemAddr=0x100.
REQ-023 Backpressure and reset:
- iIMemReady=0 for 4 cycles → oIMemReq=1 with oIMemAddr stable throughout.
- iRST=1 during WAIT → next cycle oValid=0 and state FETCH at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface instruction_fetch_if;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;

  logic              oIMemReq;
  logic [ADDR_W-1:0] oIMemAddr;
  logic              iIMemReady;
  logic              iIMemValid;
  logic [DATA_W-1:0] iIMemData;

  modport master (
    output oIMemReq,
    output oIMemAddr,
    input  iIMemReady,
    input  iIMemValid,
    input  iIMemData
  );

  modport slave (
    input  oIMemReq,
    input  oIMemAddr,
    output iIMemReady,
    output iIMemValid,
    output iIMemData
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch stage: request, await data, present to decode,
// then advance sequentially or by branch; flushes discard any in-flight response.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iStall,
  input  logic                iBranch,
  input  logic [63:0]         iBranchOffset,
  input  logic                iFlush,
  input  logic [63:0]         iFlushPC,
  instruction_fetch_if.master imem,
  output logic [31:0]         oInstruction,
  output logic [63:0]         oPC,
  output logic                oValid
);

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & WORD_MASK;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e               state_q;
  logic [ADDR_W-1:0]    fpc_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [INSTR_W-1:0]   instr_q;

  logic [ADDR_W-1:0]    flush_pc_c;
  logic [ADDR_W-1:0]    next_pc_c;

  assign flush_pc_c = iFlushPC & WORD_MASK;
  assign next_pc_c  = pc_q + (iBranch ? (iBranchOffset << 2) : ADDR_W'(4));

  // Request/valid are gated by reset so they drop in the same cycle reset is raised.
  assign imem.oIMemReq  = (state_q == S_FETCH) && !iRST;
  assign imem.oIMemAddr = fpc_q;
  assign oValid         = (state_q == S_HOLD) && !iRST;
  assign oPC            = pc_q;
  assign oInstruction   = instr_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_FETCH;
      fpc_q   <= RESET_PC_AL;
      pc_q    <= RESET_PC_AL;
      instr_q <= '0;
    end else if (iFlush) begin
      fpc_q <= flush_pc_c;
      // A response still owed by memory must be swallowed before fetching again.
      if ((state_q == S_WAIT && !imem.iIMemValid) || state_q == S_DROP) begin
        state_q <= S_DROP;
      end else begin
        state_q <= S_FETCH;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (imem.iIMemReady) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.iIMemValid) begin
            instr_q <= imem.iIMemData;
            pc_q    <= fpc_q;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!iStall) begin
            fpc_q   <= next_pc_c;
            state_q <= S_FETCH;
          end
        end
        S_DROP: begin
          if (imem.iIMemValid) begin
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vectors plus randomized traffic
// checked against a transaction-level model of the expected fetch address stream.
module tb_instruction_fetch;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iStall = 1'b0;
  logic        iBranch = 1'b0;
  logic [63:0] iBranchOffset = '0;
  logic        iFlush = 1'b0;
  logic [63:0] iFlushPC = '0;
  logic [31:0] oInstruction;
  logic [63:0] oPC;
  logic        oValid;

  instruction_fetch_if imem ();

  instruction_fetch #(.RESET_PC(64'h0)) dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iStall        (iStall),
    .iBranch       (iBranch),
    .iBranchOffset (iBranchOffset),
    .iFlush        (iFlush),
    .iFlushPC      (iFlushPC),
    .imem          (imem),
    .oInstruction  (oInstruction),
    .oPC           (oPC),
    .oValid        (oValid)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!oValid && n < 40);
    if (!oValid) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_valid: oValid never rose within %0d cycles", n);
    end
  endtask

  // Memory model: one outstanding read, data returned lat cycles after accept.
  bit          rdy_cfg = 1'b1;
  bit          rand_rdy = 1'b0;
  bit          lat_rand = 1'b0;
  int          lat = 1;
  bit          pend = 1'b0;
  int          cnt = 0;
  bit          acc = 1'b0;
  bit          dlv = 1'b0;
  bit          addr_chk = 1'b0;
  logic [63:0] paddr = '0;
  logic [63:0] acc_addr = '0;
  logic [63:0] exp_fetch = '0;

  initial begin
    bit rdy;
    imem.iIMemReady = 1'b0;
    imem.iIMemValid = 1'b0;
    imem.iIMemData  = '0;
    forever begin
      @(negedge iCLK);
      if (dlv) pend = 1'b0;
      if (acc) begin
        pend  = 1'b1;
        paddr = acc_addr;
        cnt   = lat_rand ? int'($urandom_range(0, 2)) : lat - 1;
      end
      if (iRST) pend = 1'b0;
      dlv = pend && (cnt == 0);
      if (pend && cnt > 0) cnt--;
      imem.iIMemValid = dlv;
      imem.iIMemData  = dlv ? memf(paddr) : 32'($urandom);
      rdy = rdy_cfg && (!rand_rdy || $urandom_range(0, 9) < 7) && !iFlush && !iRST && !pend;
      imem.iIMemReady = rdy;
      acc = rdy && imem.oIMemReq;
      if (acc) begin
        acc_addr = imem.oIMemAddr;
        if (addr_chk) chk("rnd_fetch_addr", imem.oIMemAddr, exp_fetch);
      end
    end
  end

  typedef struct {
    logic [63:0] flush_pc;
    logic [63:0] exp_pc;
    logic        br;
    logic [63:0] off;
    logic [63:0] exp_next;
  } vec_t;

  vec_t vt[7];

  initial begin
    int n;
    bit fl_prev;
    int delivered;

    vt[0] = '{64'h10,                  64'h10,                  1'b1, -64'sd2,                64'h8};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0,                  64'h0};
    vt[2] = '{64'h103,                 64'h100,                 1'b0, 64'h0,                  64'h104};
    vt[3] = '{64'h1000,                64'h1000,                1'b1, 64'h10,                 64'h1040};
    vt[4] = '{64'h8,                   64'h8,                   1'b1, -64'sd3,                64'hFFFF_FFFF_FFFF_FFFC};
    vt[5] = '{64'h22,                  64'h20,                  1'b1, 64'h0,                  64'h20};
    vt[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h2000_0000_0000_0000, 64'h0};

    // Reset, with flush/branch requests that reset must override.
    iFlush = 1'b1; iFlushPC = 64'h500; iBranch = 1'b1;
    tick(); tick();
    chk("rst_req", imem.oIMemReq, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_pc", oPC, 64'h0);
    chk("rst_instr", oInstruction, 32'h0);
    iRST = 1'b0; iFlush = 1'b0; iBranch = 1'b0;
    #1;
    chk("rel_req", imem.oIMemReq, 1);
    chk("rel_addr", imem.oIMemAddr, 64'h0);

    // Sequential fetch at zero-wait memory.
    wait_valid(n);
    chk("seq0_lat", 64'(n), 2);
    chk("seq0_pc", oPC, 64'h0);
    chk("seq0_instr", oInstruction, memf(64'h0));
    wait_valid(n);
    chk("seq1_lat", 64'(n), 3);
    chk("seq1_pc", oPC, 64'h4);
    chk("seq1_instr", oInstruction, memf(64'h4));

    // Stall holds the presented instruction; a branch while stalled is ignored.
    iStall = 1'b1; iBranch = 1'b1; iBranchOffset = 64'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", oValid, 1);
      chk("stall_pc", oPC, 64'h4);
      chk("stall_instr", oInstruction, memf(64'h4));
      chk("stall_req", imem.oIMemReq, 0);
    end
    iStall = 1'b0; iBranch = 1'b0;
    tick();
    chk("stall_next_req", imem.oIMemReq, 1);
    chk("stall_next_addr", imem.oIMemAddr, 64'h8);
    wait_valid(n);
    chk("seq2_lat", 64'(n), 2);
    chk("seq2_pc", oPC, 64'h8);

    // Table of flush-then-branch/sequential vectors.
    for (int i = 0; i < 7; i++) begin
      iFlush = 1'b1; iFlushPC = vt[i].flush_pc;
      tick();
      iFlush = 1'b0;
      chk("vec_flush_valid", oValid, 0);
      wait_valid(n);
      chk("vec_lat", 64'(n), 2);
      chk("vec_pc", oPC, vt[i].exp_pc);
      chk("vec_instr", oInstruction, memf(vt[i].exp_pc));
      iBranch = vt[i].br; iBranchOffset = vt[i].off;
      tick();
      iBranch = 1'b0;
      chk("vec_req", imem.oIMemReq, 1);
      chk("vec_next_addr", imem.oIMemAddr, vt[i].exp_next);
    end

    // Flush while awaiting a slow response: it must be dropped.
    lat = 3;
    tick();
    chk("wflush_in_wait", imem.oIMemReq, 0);
    iFlush = 1'b1; iFlushPC = 64'h103;
    tick();
    iFlush = 1'b0;
    chk("wflush_valid", oValid, 0);
    chk("wflush_no_req", imem.oIMemReq, 0);
    for (int k = 0; k < 10 && !imem.oIMemReq; k++) begin
      chk("wflush_drop_valid", oValid, 0);
      tick();
    end
    chk("wflush_req", imem.oIMemReq, 1);
    chk("wflush_addr", imem.oIMemAddr, 64'h100);
    lat = 1;
    wait_valid(n);
    chk("wflush_pc", oPC, 64'h100);
    chk("wflush_instr", oInstruction, memf(64'h100));

    // Backpressure: request and address stay stable while memory is not ready.
    rdy_cfg = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_req", imem.oIMemReq, 1);
      chk("bp_addr", imem.oIMemAddr, 64'h104);
      tick();
    end
    rdy_cfg = 1'b1;
    tick();
    chk("bp_accepted", imem.oIMemReq, 0);

    // Reset in the middle of a read.
    iRST = 1'b1;
    #1;
    chk("mid_rst_valid", oValid, 0);
    chk("mid_rst_req", imem.oIMemReq, 0);
    tick();
    iRST = 1'b0;
    #1;
    chk("mid_rst_pc", oPC, 64'h0);
    chk("mid_rst_instr", oInstruction, 32'h0);
    chk("mid_rst_req_after", imem.oIMemReq, 1);
    chk("mid_rst_addr", imem.oIMemAddr, 64'h0);
    chk("mid_rst_valid_after", oValid, 0);

    // Randomized traffic against the fetch-stream model.
    exp_fetch = 64'h0;
    lat_rand = 1'b1; rand_rdy = 1'b1; addr_chk = 1'b1;
    fl_prev = 1'b0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      bit fl, st, br;
      int r;
      logic [63:0] off, fpc;
      if (fl_prev) chk("rnd_flush_valid", oValid, 0);
      chk("rnd_req_valid_excl", 64'(oValid & imem.oIMemReq), 0);
      if (oValid) begin
        chk("rnd_pc", oPC, exp_fetch);
        chk("rnd_instr", oInstruction, memf(oPC));
      end
      fl = $urandom_range(0, 99) < 4;
      st = $urandom_range(0, 99) < 30;
      br = $urandom_range(0, 99) < 30;
      r = int'($urandom_range(0, 16));
      off = 64'(longint'(r - 8));
      fpc = {32'($urandom), 32'($urandom)};
      iFlush = fl; iFlushPC = fpc; iStall = st; iBranch = br; iBranchOffset = off;
      if (fl) begin
        exp_fetch = fpc & ~64'd3;
      end else if (oValid && !st) begin
        exp_fetch = exp_fetch + (br ? (off << 2) : 64'd4);
        delivered++;
      end
      fl_prev = fl;
      tick();
    end
    iFlush = 1'b0; iStall = 1'b0; iBranch = 1'b0;
    chk("rnd_progress", 64'(delivered > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
